// File: rtl/mod_arith_pkg.sv
// Shared types and constants for the sequential modular arithmetic blocks.
package mod_arith_pkg;

  localparam int unsigned WIDTH_DEF = 32;

  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int unsigned CNT_W = cnt_width(WIDTH_DEF);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    MUL    = 2'd2,
    FINISH = 2'd3
  } state_e;

endpackage

// File: rtl/mod_cond_sub.sv
// Conditional subtract: y_c = (x >= m) ? x - m : x, for x < 2m.
module mod_cond_sub #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   x,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] y_c
);

  logic [WIDTH:0] m_ext;

  assign m_ext = {1'b0, m};
  assign y_c   = (x >= m_ext) ? WIDTH'(x - m_ext) : WIDTH'(x);

endmodule

// File: rtl/mod_mul_seq.sv
// Sequential (a*b) mod m: shift-subtract reduction of a, then MSB-first
// interleaved double-and-add over the bits of b.
module mod_mul_seq
  import mod_arith_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] result,
  output logic             done
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_e           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] m_q;
  logic             m_zero;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;

  logic [CW-1:0]    idx_c;
  logic             last_c;
  logic [WIDTH:0]   red_x_c;
  logic [WIDTH-1:0] rem_nxt_c;
  logic [WIDTH:0]   dbl_x_c;
  logic [WIDTH-1:0] dbl_c;
  logic [WIDTH:0]   add_x_c;
  logic [WIDTH-1:0] add_c;
  logic [WIDTH-1:0] acc_nxt_c;

  // Bits are consumed MSB first while the counter runs upward.
  always_comb begin
    idx_c     = CW'(WIDTH - 1) - cnt;
    last_c    = (cnt == CW'(WIDTH - 1));
    red_x_c   = {rem, a_q[idx_c]};
    dbl_x_c   = {acc, 1'b0};
    add_x_c   = {1'b0, dbl_c} + {1'b0, rem};
    acc_nxt_c = b_q[idx_c] ? add_c : dbl_c;
  end

  mod_cond_sub #(.WIDTH(WIDTH)) u_sub_reduce (
    .x   (red_x_c),
    .m   (m_q),
    .y_c (rem_nxt_c)
  );

  mod_cond_sub #(.WIDTH(WIDTH)) u_sub_double (
    .x   (dbl_x_c),
    .m   (m_q),
    .y_c (dbl_c)
  );

  mod_cond_sub #(.WIDTH(WIDTH)) u_sub_add (
    .x   (add_x_c),
    .m   (m_q),
    .y_c (add_c)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      m_q    <= '0;
      m_zero <= 1'b0;
      rem    <= '0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= !start;
          if (start) begin
            a_q    <= a;
            b_q    <= b;
            m_q    <= m;
            m_zero <= (m == '0);
            rem    <= '0;
            acc    <= '0;
            cnt    <= '0;
            state  <= REDUCE;
          end
        end
        REDUCE: begin
          rem <= rem_nxt_c;
          cnt <= last_c ? '0 : cnt + CW'(1);
          if (last_c) state <= MUL;
        end
        MUL: begin
          acc <= acc_nxt_c;
          cnt <= last_c ? '0 : cnt + CW'(1);
          if (last_c) state <= FINISH;
        end
        FINISH: begin
          // A zero modulus was flagged at start and forces a zero result.
          result <= m_zero ? '0 : acc;
          done   <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_mul_seq.sv
// Scoreboard bench for mod_mul_seq: driver queues expected results, a monitor
// checks each rising done against the queue head (value and latency).
module tb_mod_mul_seq;
  import mod_arith_pkg::*;

  localparam int unsigned W   = WIDTH_DEF;
  localparam int          LAT = 65;

  typedef struct {
    logic [W-1:0] res;
    int           issue;
    bit           chk_lat;
  } exp_t;

  logic         clk   = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic [W-1:0] m     = '0;
  logic [W-1:0] result;
  logic         done;

  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic prev_done = 1'b0;

  mod_mul_seq #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .a      (a),
    .b      (b),
    .m      (m),
    .result (result),
    .done   (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every 0->1 transition of done is one completion.
  always @(negedge clk) begin
    if (done === 1'b1 && prev_done !== 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: done rose at cycle %0d, expected no completion", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("result", result, mon_e.res);
        if (mon_e.chk_lat) check_int("latency", cyc - mon_e.issue, LAT);
      end
    end
    prev_done = done;
  end

  task automatic wait_done();
    int k;
    k = 0;
    while (done !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL done_timeout: done=%b after %0d cycles, expected 1", done, k);
    end
  endtask

  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic [W-1:0] im, input logic [W-1:0] exp_res);
    a     = ia;
    b     = ib;
    m     = im;
    start = 1'b1;
    sb.push_back('{exp_res, cyc + 1, 1'b1});
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", W'(done), W'(0));
  endtask

  initial begin
    int r;
    int low;

    // Reset state and recovery
    repeat (3) @(negedge clk);
    check("reset_done", W'(done), W'(0));
    check("reset_result", result, '0);
    reset = 1'b1;
    sb.push_back('{W'(0), 0, 1'b0});
    wait_done();

    // Basic, unreduced a, width extremes, degenerate moduli
    issue(W'(3), W'(5), W'(7), W'(1));                       wait_done();
    issue(W'(100), W'(3), W'(7), W'(6));                     wait_done();
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFB, W'(16)); wait_done();
    issue(32'hFFFF_FFFF, W'(1), 32'h8000_0000, 32'h7FFF_FFFF);  wait_done();
    issue(W'(9), W'(9), W'(0), W'(0));                       wait_done();
    issue(W'(12345), W'(678), W'(1), W'(0));                 wait_done();
    issue(W'(5), W'(0), W'(7), W'(0));                       wait_done();

    // Operand changes and repeated start while busy are ignored
    issue(W'(1000), W'(1000), W'(997), W'(9));
    repeat (2) @(negedge clk);
    a = W'(5); b = W'(6); m = W'(11);
    repeat (7) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    low = 0;
    repeat (80) begin
      @(negedge clk);
      if (done !== 1'b1) low++;
    end
    check_int("no_second_op", low, 0);

    // Reset mid-operation abandons it and clears result
    a = W'(7); b = W'(8); m = W'(9);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (18) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midreset_done", W'(done), W'(0));
    check("midreset_result", result, '0);
    @(negedge clk);
    reset = 1'b1;
    sb.push_back('{W'(0), 0, 1'b0});
    wait_done();
    check("post_reset_result", result, '0);

    // Exponent-controller chain: 2*2, then feed result back into a
    issue(W'(2), W'(2), W'(1000), W'(4));  wait_done();
    issue(result, W'(2), W'(1000), W'(8));  wait_done();
    issue(result, W'(2), W'(1000), W'(16)); wait_done();

    // start held high: a new operation begins on every IDLE cycle
    a = W'(2); b = W'(2); m = W'(1000);
    start = 1'b1;
    r = cyc;
    for (int i = 0; i < 3; i++) sb.push_back('{W'(4), r + 1 + i * (LAT + 1), 1'b1});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("held_busy", W'(done), W'(0));
      wait_done();
      if (i == 2) start = 1'b0;
    end
    repeat (5) @(negedge clk);
    check("idle_after_release", W'(done), W'(1));

    check_int("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
